// File: rtl/ssd_scan_controller_pkg.sv
// ssd_scan_controller_pkg: shared segment constants and width helpers for the scan controller
package ssd_scan_controller_pkg;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   function automatic int widthOf(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ssd_scan_controller_decoder.sv
// ssd_scan_controller_decoder: 4-bit value to active-low seven-segment pattern (a..g = bit6..bit0)
module ssd_scan_controller_decoder
   import ssd_scan_controller_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);
   always_comb begin
      case (digit)
         4'd0:    seg = 7'b0000001;
         4'd1:    seg = 7'b1001111;
         4'd2:    seg = 7'b0010010;
         4'd3:    seg = 7'b0000110;
         4'd4:    seg = 7'b1001100;
         4'd5:    seg = 7'b0100100;
         4'd6:    seg = 7'b0100000;
         4'd7:    seg = 7'b0001111;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0000100;
         default: seg = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: multiplexed seven-segment scanner with frame-aligned updates.
// Optional leading-zero suppression via SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_controller
   import ssd_scan_controller_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    load,
   input  logic                    blank,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    pending,
   output logic                    frame_tick
);
   localparam int CW = widthOf(REFRESH_DIV);
   localparam int IW = widthOf(NUM_DIGITS);
   logic [CW-1:0]           slotCnt;
   logic [IW-1:0]           digitIdx;
   logic [4*NUM_DIGITS-1:0] shadow, display;
   logic [NUM_DIGITS-1:0]   suppress;
   logic [3:0]              nibble;
   logic [6:0]              segCode;
   logic                    slotEnd, frameEnd, active;
   always_comb begin
      slotEnd  = slotCnt == CW'(REFRESH_DIV - 1);
      frameEnd = slotEnd && digitIdx == IW'(NUM_DIGITS - 1);
      nibble   = display[4*digitIdx +: 4];
      active   = slotCnt >= CW'(BLANK_CYCLES) && !blank && !suppress[digitIdx];
   end
   always_comb begin
`ifdef SSD_LEADING_ZERO_BLANK_EN
      logic allZero;
      suppress = '0;
      allZero  = 1'b1;
      // scan from the top digit down; digit 0 is never suppressed
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         allZero     = allZero && display[4*k +: 4] == 4'd0;
         suppress[k] = allZero;
      end
`else
      suppress = '0;
`endif
   end
   ssd_scan_controller_decoder uDecoder (.digit(nibble), .seg(segCode));
   always_ff @(posedge clk) begin
      if (rst) begin
         slotCnt    <= '0;
         digitIdx   <= '0;
         shadow     <= '0;
         display    <= '0;
         pending    <= 1'b0;
         frame_tick <= 1'b0;
         seg        <= SEG_BLANK;
         anode      <= '1;
      end else begin
         slotCnt    <= slotEnd ? '0 : slotCnt + 1'b1;
         if (slotEnd) digitIdx <= frameEnd ? '0 : digitIdx + 1'b1;
         // the boundary consumes the pre-load shadow; a same-cycle load stays pending
         if (frameEnd && pending) display <= shadow;
         if (load) shadow <= digits_in;
         pending    <= load ? 1'b1 : (frameEnd ? 1'b0 : pending);
         frame_tick <= frameEnd;
         seg        <= active ? segCode : SEG_BLANK;
         anode      <= active ? ~(NUM_DIGITS'(1) << digitIdx) : '1;
      end
   end
endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb_ssd_scan_controller: directed checks of scanning, frame-aligned loads, blanking and reset
module tb_ssd_scan_controller;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] digitsIn = '0;
   logic        load = 1'b0;
   logic        blank = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  anode;
   logic        pending, frameTick;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   bit          lzb;

   ssd_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .digits_in(digitsIn), .load(load), .blank(blank),
      .seg(seg), .anode(anode), .pending(pending), .frame_tick(frameTick)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goTo(input int n);
      while (cyc < n) step();
   endtask

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
`ifdef SSD_LEADING_ZERO_BLANK_EN
      lzb = 1'b1;
`else
      lzb = 1'b0;
`endif
      repeat (3) step();
      check("rst_seg", 16'(seg), 16'b1111111);
      check("rst_anode", 16'(anode), 16'b1111);
      check("rst_pending", 16'(pending), 16'd0);
      check("rst_tick", 16'(frameTick), 16'd0);
      rst = 1'b0;
      cyc = 0;
      goTo(1);
      check("gap_anode", 16'(anode), 16'b1111);
      goTo(2);
      check("first_anode", 16'(anode), 16'b1110);
      check("first_seg", 16'(seg), 16'b0000001);
      // load 1239 mid-frame, applied at the first boundary
      digitsIn = 16'h1239; load = 1'b1;
      goTo(3);
      load = 1'b0;
      check("load_pending", 16'(pending), 16'd1);
      goTo(15);
      check("pending_hold", 16'(pending), 16'd1);
      check("tick_low", 16'(frameTick), 16'd0);
      goTo(16);
      check("pending_clr", 16'(pending), 16'd0);
      check("tick_high", 16'(frameTick), 16'd1);
      goTo(17);
      check("tick_once", 16'(frameTick), 16'd0);
      goTo(18);
      check("d9_seg", 16'(seg), 16'b0000100);
      check("d9_anode", 16'(anode), 16'b1110);
      goTo(22);
      check("d3_seg", 16'(seg), 16'b0000110);
      check("d3_anode", 16'(anode), 16'b1101);
      goTo(30);
      check("d1_seg", 16'(seg), 16'b1001111);
      check("d1_anode", 16'(anode), 16'b0111);
      // non-decimal nibble keeps its anode but lights nothing
      digitsIn = 16'h00A0; load = 1'b1;
      goTo(31);
      load = 1'b0;
      goTo(34);
      check("a0_s0_seg", 16'(seg), 16'b0000001);
      check("a0_s0_anode", 16'(anode), 16'b1110);
      goTo(38);
      check("a_seg", 16'(seg), 16'b1111111);
      check("a_anode", 16'(anode), 16'b1101);
      goTo(42);
      check("a0_s2_anode", 16'(anode), lzb ? 16'b1111 : 16'b1011);
      check("a0_s2_seg", 16'(seg), lzb ? 16'b1111111 : 16'b0000001);
      // load coinciding with the boundary
      goTo(44);
      digitsIn = 16'h1111; load = 1'b1;
      goTo(45);
      load = 1'b0;
      goTo(47);
      digitsIn = 16'h2222; load = 1'b1;
      goTo(48);
      load = 1'b0;
      check("coinc_pending", 16'(pending), 16'd1);
      check("coinc_tick", 16'(frameTick), 16'd1);
      goTo(50);
      check("ones_s0_seg", 16'(seg), 16'b1001111);
      goTo(62);
      check("ones_s3_seg", 16'(seg), 16'b1001111);
      check("ones_s3_anode", 16'(anode), 16'b0111);
      goTo(64);
      check("twos_pending", 16'(pending), 16'd0);
      goTo(66);
      check("twos_s0_seg", 16'(seg), 16'b0010010);
      check("twos_s0_anode", 16'(anode), 16'b1110);
      goTo(78);
      check("twos_s3_seg", 16'(seg), 16'b0010010);
      // blank for a whole frame
      goTo(80);
      blank = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         check("blank_anode", 16'(anode), 16'b1111);
      end
      check("blank_tick", 16'(frameTick), 16'd1);
      blank = 1'b0;
      // reset mid-slot discards a pending load
      digitsIn = 16'h4444; load = 1'b1;
      goTo(97);
      load = 1'b0;
      check("pre_rst_pending", 16'(pending), 16'd1);
      goTo(98);
      rst = 1'b1;
      goTo(99);
      check("mid_rst_seg", 16'(seg), 16'b1111111);
      check("mid_rst_anode", 16'(anode), 16'b1111);
      check("mid_rst_pending", 16'(pending), 16'd0);
      check("mid_rst_tick", 16'(frameTick), 16'd0);
      rst = 1'b0;
      cyc = 0;
      goTo(16);
      check("post_rst_pending", 16'(pending), 16'd0);
      check("post_rst_tick", 16'(frameTick), 16'd1);
      goTo(18);
      check("post_rst_seg", 16'(seg), 16'b0000001);
      check("post_rst_anode", 16'(anode), 16'b1110);
      // leading-zero suppression behaviour
      digitsIn = 16'h0050; load = 1'b1;
      goTo(20);
      load = 1'b0;
      goTo(34);
      check("lz50_s0_seg", 16'(seg), 16'b0000001);
      check("lz50_s0_anode", 16'(anode), 16'b1110);
      goTo(38);
      check("lz50_s1_seg", 16'(seg), 16'b0100100);
      check("lz50_s1_anode", 16'(anode), 16'b1101);
      goTo(42);
      check("lz50_s2_anode", 16'(anode), lzb ? 16'b1111 : 16'b1011);
      goTo(46);
      check("lz50_s3_anode", 16'(anode), lzb ? 16'b1111 : 16'b0111);
      digitsIn = 16'h0000; load = 1'b1;
      goTo(47);
      load = 1'b0;
      goTo(50);
      check("lz00_s0_seg", 16'(seg), 16'b0000001);
      check("lz00_s0_anode", 16'(anode), 16'b1110);
      goTo(54);
      check("lz00_s1_anode", 16'(anode), lzb ? 16'b1111 : 16'b1101);
      goTo(62);
      check("lz00_s3_anode", 16'(anode), lzb ? 16'b1111 : 16'b0111);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
